// File: rtl/qsys_cpu_mult_pkg.sv
// qsys_cpu_mult_pkg: mode encoding and signedness helpers for the pipelined multiplier
package qsys_cpu_mult_pkg;
  localparam int MODE_W = 2;
  typedef enum logic [MODE_W-1:0] {
    MUL    = 2'd0,
    MULXUU = 2'd1,
    MULXSU = 2'd2,
    MULXSS = 2'd3
  } mode_e;
  function automatic logic a_signed(input mode_e m);
    return m == MULXSU || m == MULXSS;
  endfunction
  function automatic logic b_signed(input mode_e m);
    return m == MULXSS;
  endfunction
endpackage

// File: rtl/qsys_cpu_mult_pp.sv
// qsys_cpu_mult_pp: one registered H x H unsigned partial-product multiplier with hold enable
module qsys_cpu_mult_pp #(
  parameter int H = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [H-1:0] a,
  input  logic [H-1:0] b,
  output logic [2*H-1:0] p
);
  logic [2*H-1:0] p_d, p_q;
  // capture a fresh product on advance, hold it during a stall
  always_comb p_d = en ? {{H{1'b0}}, a} * {{H{1'b0}}, b} : p_q;
  // product register cleared by reset like the original aclr cell
  always_ff @(posedge clk or posedge reset)
    if (reset) p_q <= '0;
    else       p_q <= p_d;
  assign p = p_q;
endmodule

// File: rtl/qsys_cpu_mult_pipe.sv
// qsys_cpu_mult_pipe: 2/3-cycle pipelined multiplier with global stall; optional flush via QSYS_CPU_MULT_PIPE_FLUSH_EN
module qsys_cpu_mult_pipe
  import qsys_cpu_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
`ifdef QSYS_CPU_MULT_PIPE_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [MODE_W-1:0] in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result
);
  localparam int H = DATA_W / 2;
  if (DATA_W % 2 != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_w
    $error("DATA_W must be even and within 8..64");
  end
  if (LATENCY != 2 && LATENCY != 3) begin : g_bad_lat
    $error("LATENCY must be 2 or 3");
  end
  logic adv, clr;
  assign in_ready = !out_valid || out_ready;
  assign adv      = in_ready;
`ifdef QSYS_CPU_MULT_PIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif
  logic              s0_valid;
  logic [DATA_W-1:0] s0_a, s0_b;
  mode_e             s0_mode;
  if (LATENCY == 3) begin : g_in_reg
    logic              v_d, v_q;
    logic [DATA_W-1:0] a_d, a_q, b_d, b_q;
    mode_e             m_d, m_q;
    // input stage: valid dropped by flush, operands follow the global advance
    always_comb begin
      v_d = clr ? 1'b0 : adv ? in_valid : v_q;
      a_d = adv ? in_a : a_q;
      b_d = adv ? in_b : b_q;
      m_d = adv ? mode_e'(in_mode) : m_q;
    end
    // input stage registers
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        m_q <= MUL;
      end else begin
        v_q <= v_d;
        a_q <= a_d;
        b_q <= b_d;
        m_q <= m_d;
      end
    end
    assign s0_valid = v_q;
    assign s0_a     = a_q;
    assign s0_b     = b_q;
    assign s0_mode  = m_q;
  end else begin : g_in_wire
    assign s0_valid = in_valid;
    assign s0_a     = in_a;
    assign s0_b     = in_b;
    assign s0_mode  = mode_e'(in_mode);
  end
  logic [DATA_W-1:0] pp_ll, pp_lh, pp_hl, pp_hh;
  qsys_cpu_mult_pp #(.H(H)) u_pp_ll (
    .clk(clk), .reset(reset), .en(adv), .a(s0_a[H-1:0]), .b(s0_b[H-1:0]), .p(pp_ll)
  );
  qsys_cpu_mult_pp #(.H(H)) u_pp_lh (
    .clk(clk), .reset(reset), .en(adv), .a(s0_a[H-1:0]), .b(s0_b[DATA_W-1:H]), .p(pp_lh)
  );
  qsys_cpu_mult_pp #(.H(H)) u_pp_hl (
    .clk(clk), .reset(reset), .en(adv), .a(s0_a[DATA_W-1:H]), .b(s0_b[H-1:0]), .p(pp_hl)
  );
  qsys_cpu_mult_pp #(.H(H)) u_pp_hh (
    .clk(clk), .reset(reset), .en(adv), .a(s0_a[DATA_W-1:H]), .b(s0_b[DATA_W-1:H]), .p(pp_hh)
  );
  logic              s1_valid_d, s1_valid_q;
  logic [DATA_W-1:0] s1_a_d, s1_a_q, s1_b_d, s1_b_q;
  mode_e             s1_mode_d, s1_mode_q;
  // stage 1 sideband: operands travel with the partial products for sign correction
  always_comb begin
    s1_valid_d = clr ? 1'b0 : adv ? s0_valid : s1_valid_q;
    s1_a_d     = adv ? s0_a : s1_a_q;
    s1_b_d     = adv ? s0_b : s1_b_q;
    s1_mode_d  = adv ? s0_mode : s1_mode_q;
  end
  // stage 1 sideband registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_mode_q  <= MUL;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_mode_q  <= s1_mode_d;
    end
  end
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   hi, sel;
  logic                out_valid_d, out_valid_q;
  logic [DATA_W-1:0]   out_result_d, out_result_q;
  // stage 2: unsigned sum, signed fix-up of the high half, half select, output hold
  always_comb begin
    prod = {{DATA_W{1'b0}}, pp_ll}
         + ({{DATA_W{1'b0}}, pp_lh} << H)
         + ({{DATA_W{1'b0}}, pp_hl} << H)
         + {pp_hh, {DATA_W{1'b0}}};
    hi = prod[2*DATA_W-1:DATA_W]
       - (a_signed(s1_mode_q) && s1_a_q[DATA_W-1] ? s1_b_q : '0)
       - (b_signed(s1_mode_q) && s1_b_q[DATA_W-1] ? s1_a_q : '0);
    sel          = s1_mode_q == MUL ? prod[DATA_W-1:0] : hi;
    out_valid_d  = clr ? 1'b0 : adv ? s1_valid_q : out_valid_q;
    out_result_d = adv ? sel : out_result_q;
  end
  // output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
endmodule

// File: tb/tb_qsys_cpu_mult_pipe.sv
// tb_qsys_cpu_mult_pipe: random and directed checks of both configurations against an arithmetic model
module tb_qsys_cpu_mult_pipe;
  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] a_drv, b_drv;
  logic [1:0]  mode_drv;
  logic        rdy32, ov32, rdy16, ov16;
  logic [31:0] res32;
  logic [15:0] res16;
  int          n_chk = 0, n_err = 0, n_out = 0, cyc = 0, w = 32, lat = 2;
  logic        sel = 1'b0, chk_lat = 1'b1, rdy_s, prev_stall = 1'b0;
  logic [63:0] prev_res, last_res;
  typedef struct { logic [63:0] exp; int t; } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  qsys_cpu_mult_pipe #(.DATA_W(32), .LATENCY(2)) u_dut32 (
    .clk(clk), .reset(reset),
`ifdef QSYS_CPU_MULT_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(rdy32), .in_a(a_drv), .in_b(b_drv), .in_mode(mode_drv),
    .out_valid(ov32), .out_ready(out_ready), .out_result(res32)
  );
  qsys_cpu_mult_pipe #(.DATA_W(16), .LATENCY(3)) u_dut16 (
    .clk(clk), .reset(reset),
`ifdef QSYS_CPU_MULT_PIPE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(rdy16), .in_a(a_drv[15:0]), .in_b(b_drv[15:0]), .in_mode(mode_drv),
    .out_valid(ov16), .out_ready(out_ready), .out_result(res16)
  );

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b, input int m, input int wd);
    logic [63:0] mask;
    logic signed [127:0] ae, be, p;
    mask = (64'd1 << wd) - 64'd1;
    ae = $signed({64'd0, a & mask});
    be = $signed({64'd0, b & mask});
    if ((m == 2 || m == 3) && a[wd-1]) ae = ae - (128'sd1 <<< wd);
    if (m == 3 && b[wd-1]) be = be - (128'sd1 <<< wd);
    p = ae * be;
    if (m != 0) p = p >>> wd;
    return p[63:0] & mask;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1 << (w - 1);
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    logic ov;
    logic [63:0] res;
    exp_t e;
    #1;
    rdy_s = sel ? rdy16 : rdy32;
    ov    = sel ? ov16 : ov32;
    res   = sel ? {48'd0, res16} : {32'd0, res32};
    chk("in_ready", rdy_s, !ov || out_ready);
    if (prev_stall && ov) chk("stable", res, prev_res);
    prev_stall = ov && !out_ready;
    prev_res   = res;
    if (ov && out_ready) begin
      n_out++;
      last_res = res;
      chk("pending", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("result", res, e.exp);
        if (chk_lat) chk("latency", cyc - e.t, lat);
      end
    end
    if (in_valid && rdy_s && !flush) q.push_back('{model(a_drv, b_drv, mode_drv, w), cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    chk("drain", q.size(), 0);
  endtask

  task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [1:0] m, input logic [31:0] exp);
    int n0;
    n0 = n_out;
    a_drv = a; b_drv = b; mode_drv = m; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (lat) step();
    chk(tag, last_res, {32'd0, exp});
    chk({tag, "_cnt"}, n_out - n0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, sent;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a_drv = '0; b_drv = '0; mode_drv = '0;
    #1;
    chk("rst_ov", ov32, 0);
    chk("rst_res", res32, 0);
    chk("rst_rdy", rdy32, 1);
    chk("rst_ov16", ov16, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_rdy", rdy32, 1);
    @(negedge clk);

    txn("mul_basic", 32'h0001_0003, 32'h0002_0005, 2'd0, 32'h000B_000F);
    txn("mulxss", 32'hFFFF_FFFF, 32'h0000_0002, 2'd3, 32'hFFFF_FFFF);
    txn("mulxuu", 32'hFFFF_FFFF, 32'h0000_0002, 2'd1, 32'h0000_0001);
    txn("mulxsu", 32'h8000_0000, 32'hFFFF_FFFF, 2'd2, 32'h8000_0000);
    txn("mul_signed_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 32'h0000_0001);

    chk_lat = 1'b0;
    n0 = n_out; sent = 0;
    for (int k = 0; k < 20; k++) begin
      in_valid = sent < 8;
      a_drv = pick(); b_drv = pick(); mode_drv = 2'($urandom_range(0, 3));
      out_ready = !(k >= 3 && k <= 5);
      step();
      if (in_valid && rdy_s) sent++;
      chk("stall_rdy", rdy_s, !(k >= 3 && k <= 5));
    end
    chk("stream_cnt", n_out - n0, 8);
    chk("stream_q", q.size(), 0);
    chk_lat = 1'b1;

    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; a_drv = pick(); b_drv = pick(); mode_drv = 2'($urandom_range(0, 3));
      step();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("inflight_ov", ov32, 0);
    chk("inflight_res", res32, 0);
    chk("inflight_rdy", rdy32, 1);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    n0 = n_out;
    repeat (8) step();
    chk("post_rst_out", n_out - n0, 0);

`ifdef QSYS_CPU_MULT_PIPE_FLUSH_EN
    n0 = n_out;
    in_valid = 1'b1; out_ready = 1'b1;
    a_drv = pick(); b_drv = pick(); step();
    a_drv = pick(); b_drv = pick(); step();
    out_ready = 1'b0; flush = 1'b1; a_drv = pick(); step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    q.delete();
    #1 chk("flush_ov", ov32, 0);
    repeat (5) step();
    chk("flush_cnt", n_out - n0, 0);
    txn("flush_next", 32'd7, 32'd9, 2'd0, 32'd63);
`endif

    chk_lat = 1'b0;
    for (int k = 0; k < 600; k++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      a_drv = pick(); b_drv = pick(); mode_drv = 2'($urandom_range(0, 3));
      step();
    end
    drain();

    sel = 1'b1; w = 16; lat = 3; chk_lat = 1'b1;
    do_reset();
    n0 = n_out;
    for (int k = 0; k < 10000; k++) begin
      in_valid = 1'b1; out_ready = 1'b1;
      a_drv = pick(); b_drv = pick(); mode_drv = 2'($urandom_range(0, 3));
      step();
    end
    drain();
    chk("w16_cnt", n_out - n0, 10000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
